// File: rtl/pipe_hazard_if.sv
// Pipeline control bundle between the core datapath (master) and the hazard
// controller (slave).
`timescale 1ns/1ps
interface pipe_hazard_if #(
   parameter int unsigned BIT_WIDTH = 32
);
   logic                 i_imem_ready;
   logic                 i_br_taken;
   logic [BIT_WIDTH-1:0] i_br_target;
   logic                 i_dmem_req;
   logic                 i_dmem_ack;
   logic                 o_pc_en;
   logic                 o_pc_sel;
   logic [BIT_WIDTH-1:0] o_pc_target;
   logic                 o_fd_en;
   logic                 o_fd_flush;
   logic                 o_ex_stall;
   logic                 o_mem_err;
   logic [1:0]           o_state;
   logic [15:0]          o_stall_cnt;
   logic [15:0]          o_flush_cnt;

   modport master (
      output i_imem_ready, i_br_taken, i_br_target, i_dmem_req, i_dmem_ack,
      input  o_pc_en, o_pc_sel, o_pc_target, o_fd_en, o_fd_flush, o_ex_stall,
      input  o_mem_err, o_state, o_stall_cnt, o_flush_cnt
   );

   modport slave (
      input  i_imem_ready, i_br_taken, i_br_target, i_dmem_req, i_dmem_ack,
      output o_pc_en, o_pc_sel, o_pc_target, o_fd_en, o_fd_flush, o_ex_stall,
      output o_mem_err, o_state, o_stall_cnt, o_flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 3-stage RV32I core: boot NOP injection, branch
// flushes, data-memory stall freeze with watchdog, and saturating perf counters.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
   parameter int unsigned BIT_WIDTH   = 32,
   parameter int unsigned BOOT_CYCLES = 2,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input logic         i_clk,
   input logic         i_rstn,
   pipe_hazard_if.slave bus
);
   localparam int unsigned BootW = $clog2(BOOT_CYCLES + 1);
   localparam int unsigned WdogW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      StBoot    = 2'd0,
      StRun     = 2'd1,
      StMemWait = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [BootW-1:0]     boot_q, boot_d;
   logic [WdogW-1:0]     wdog_q, wdog_d;
   logic                 pend_valid_q, pend_valid_d;
   logic [BIT_WIDTH-1:0] pend_target_q, pend_target_d;
   logic                 mem_err_q, mem_err_d;
   logic [15:0]          stall_cnt_q, stall_cnt_d;
   logic [15:0]          flush_cnt_q, flush_cnt_d;

   logic pc_en, pc_sel, fd_en, fd_flush, ex_stall, release_wait;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q       <= StBoot;
         boot_q        <= '0;
         wdog_q        <= '0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
         mem_err_q     <= 1'b0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         boot_q        <= boot_d;
         wdog_q        <= wdog_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         mem_err_q     <= mem_err_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      boot_d        = boot_q;
      wdog_d        = wdog_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      mem_err_d     = mem_err_q;
      stall_cnt_d   = stall_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      pc_en         = 1'b0;
      pc_sel        = 1'b0;
      fd_en         = 1'b1;
      fd_flush      = 1'b1;
      ex_stall      = 1'b0;
      release_wait  = bus.i_dmem_ack || (wdog_q == WdogW'(MEM_TIMEOUT));

      unique case (state_q)
         StBoot: begin
            if (boot_q == BootW'(BOOT_CYCLES - 1)) begin
               state_d = StRun;
               boot_d  = '0;
            end else begin
               boot_d = boot_q + BootW'(1);
            end
         end
         StRun: begin
            if (bus.i_dmem_req && !bus.i_dmem_ack) begin
               fd_en    = 1'b0;
               fd_flush = 1'b0;
               ex_stall = 1'b1;
               state_d  = StMemWait;
               wdog_d   = '0;
               // A branch cannot redirect while execute is frozen; defer it to the ack.
               if (bus.i_br_taken) begin
                  pend_valid_d  = 1'b1;
                  pend_target_d = bus.i_br_target;
               end
            end else if (bus.i_br_taken) begin
               pc_en       = 1'b1;
               pc_sel      = 1'b1;
               flush_cnt_d = sat_inc(flush_cnt_q);
            end else begin
               pc_en    = bus.i_imem_ready;
               fd_flush = !bus.i_imem_ready;
            end
         end
         StMemWait: begin
            if (release_wait) begin
               state_d      = StRun;
               pend_valid_d = 1'b0;
               if (!bus.i_dmem_ack) mem_err_d = 1'b1;
               if (pend_valid_q) begin
                  pc_en       = 1'b1;
                  pc_sel      = 1'b1;
                  flush_cnt_d = sat_inc(flush_cnt_q);
               end else begin
                  pc_en    = bus.i_imem_ready;
                  fd_flush = !bus.i_imem_ready;
               end
            end else begin
               fd_en       = 1'b0;
               fd_flush    = 1'b0;
               ex_stall    = 1'b1;
               stall_cnt_d = sat_inc(stall_cnt_q);
               wdog_d      = wdog_q + WdogW'(1);
            end
         end
         default: state_d = StBoot;
      endcase
   end

   assign bus.o_pc_en       = pc_en;
   assign bus.o_pc_sel      = pc_sel;
   assign bus.o_pc_target   = pend_valid_q ? pend_target_q : bus.i_br_target;
   assign bus.o_fd_en       = fd_en;
   assign bus.o_fd_flush    = fd_flush;
   assign bus.o_ex_stall    = ex_stall;
   assign bus.o_mem_err     = mem_err_q;
   assign bus.o_state       = state_q;
   assign bus.o_stall_cnt   = stall_cnt_q;
   assign bus.o_flush_cnt   = flush_cnt_q;
endmodule
